// File: rtl/l1a_match_fifo_if.sv
// Bus bundle for the L1A match FIFO: trigger-side inputs, readout handshake and status outputs.
// The slave modport is the FIFO's view; the master modport is the driving side.
interface l1a_match_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 12
);
    logic              L1ACFEB;
    logic [4:0]        L1A_MATCH;
    logic              LCTERR;
    logic              CLR;
    logic              RD_EN;
    logic [CNT_W+4:0]  DOUT;
    logic              DOUT_VLD;
    logic              FULL;
    logic              EMPTY;
    logic [ADDR_W:0]   WORD_CNT;
    logic              OVFL;
    logic [7:0]        LCTERR_CNT;

    modport master (
        output L1ACFEB, L1A_MATCH, LCTERR, CLR, RD_EN,
        input  DOUT, DOUT_VLD, FULL, EMPTY, WORD_CNT, OVFL, LCTERR_CNT
    );

    modport slave (
        input  L1ACFEB, L1A_MATCH, LCTERR, CLR, RD_EN,
        output DOUT, DOUT_VLD, FULL, EMPTY, WORD_CNT, OVFL, LCTERR_CNT
    );
endinterface

// File: rtl/l1a_match_fifo.sv
// First-word-fall-through FIFO of {event number, CFEB match bits}, one entry per L1A rising edge,
// with sticky overflow and a saturating LCT error counter.
module l1a_match_fifo #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 12
) (
    input  logic              CLK,
    input  logic              RST_N,
    l1a_match_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int DW    = CNT_W + 5;

    logic              l1a_s1;
    logic              l1a_s2;
    logic              wr_q;
    logic [4:0]        match_s1;
    logic [4:0]        match_q;
    logic [CNT_W-1:0]  evt_cnt;
    logic [CNT_W-1:0]  evt_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_nxt;
    logic              full_q;
    logic              empty_q;
    logic              ovfl_q;
    logic [7:0]        lcterr_cnt;
    logic              do_pop;
    logic              do_push;
    logic              do_drop;
    logic [DW-1:0]     mem [DEPTH];

    // Two-stage edge detect; this history survives CLR so a held L1A cannot re-trigger.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            l1a_s1   <= 1'b0;
            l1a_s2   <= 1'b0;
            wr_q     <= 1'b0;
            match_s1 <= '0;
            match_q  <= '0;
        end else begin
            l1a_s1   <= bus.L1ACFEB;
            l1a_s2   <= l1a_s1;
            wr_q     <= l1a_s1 & ~l1a_s2;
            match_s1 <= bus.L1A_MATCH;
            match_q  <= match_s1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        do_pop       = 1'b0;
        do_push      = 1'b0;
        do_drop      = 1'b0;
        word_cnt_nxt = word_cnt;
        evt_nxt      = evt_cnt + 1'b1;
        if (!bus.CLR) begin
            do_pop  = bus.RD_EN & ~empty_q;
            do_push = wr_q & (~full_q | do_pop);
            do_drop = wr_q & full_q & ~do_pop;
            if (do_push && !do_pop) begin
                word_cnt_nxt = word_cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                word_cnt_nxt = word_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_cnt   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovfl_q     <= 1'b0;
            lcterr_cnt <= '0;
        end else if (bus.CLR) begin
            evt_cnt    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_cnt   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovfl_q     <= 1'b0;
            lcterr_cnt <= '0;
        end else begin
            // Event numbers advance on every L1A, including dropped ones, so gaps reveal overflow.
            if (wr_q) begin
                evt_cnt <= evt_nxt;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            word_cnt <= word_cnt_nxt;
            full_q   <= (word_cnt_nxt == (ADDR_W+1)'(DEPTH));
            empty_q  <= (word_cnt_nxt == '0);
            if (do_drop) begin
                ovfl_q <= 1'b1;
            end
            if (bus.LCTERR && (lcterr_cnt != 8'hFF)) begin
                lcterr_cnt <= lcterr_cnt + 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; the pointers and EMPTY flag alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= {evt_nxt, match_q};
        end
    end

    assign bus.DOUT       = mem[rd_ptr];
    assign bus.DOUT_VLD   = ~empty_q;
    assign bus.FULL       = full_q;
    assign bus.EMPTY      = empty_q;
    assign bus.WORD_CNT   = word_cnt;
    assign bus.OVFL       = ovfl_q;
    assign bus.LCTERR_CNT = lcterr_cnt;
endmodule
